mips_multicycle_control: RTL and testbench

- Next-generation MIPS control unit for the multicycle datapath.
- Replaces the single-cycle main/ALU decoder pair with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a memory-ready handshake, optional BNE support, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register (Opcode/Funct) and the shared multicycle datapath (PC, unified memory, register file, ALU).

---
 rtl/mips_ctrl_pkg.sv | 57 +++++
 rtl/mips_alu_decoder.sv | 33 +++
 rtl/mips_multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS control units.
// Contains the multicycle FSM state encoding, the opcode and funct field
// values, the ALUOp / ALUControl encodings, and the ALUSrcB / PCSrc
// mux-select encodings used by the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus the R-type funct field to the
// 3-bit ALU operation. Shared with the single-cycle control unit.
// Ports:
//   alu_op_i      - add / sub / decode-funct request from the main control
//   funct_i       - IR[5:0]
//   alu_control_o - ALU operation select
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t      alu_op_i,
  input  logic [5:0]  funct_i,
  output logic [2:0]  alu_control_o
);

  always_comb begin
    alu_control_o = ALUC_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALUC_ADD;
      ALUOP_SUB: alu_control_o = ALUC_SUB;
      default: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALUC_ADD;
          FN_SUB:  alu_control_o = ALUC_SUB;
          FN_AND:  alu_control_o = ALUC_AND;
          FN_OR:   alu_control_o = ALUC_OR;
          FN_SLT:  alu_control_o = ALUC_SLT;
          default: alu_control_o = ALUC_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore-style control FSM for the MIPS multicycle datapath.
// Sequences fetch/decode/execute/memory/writeback, waits on MemReady in the
// memory-touching states (when MEM_WAIT_EN), flags unsupported opcodes with
// IllegalOp and counts retired instructions in InstrCount.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   Opcode, Funct       - instruction register fields
//   Zero, MemReady      - ALU zero flag, memory access complete
//   PCEn ... ALUControl - datapath control strobes and mux selects
//   IllegalOp           - pulse in DECODE for an unsupported opcode
//   InstrCount          - retired-instruction counter (wraps)
//   StateDbg            - current FSM state, for observation
// All outputs are forced to zero while RST is high.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W  = 3,
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          BNE_EN      = 1'b1,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [5:0]            Opcode,
  input  logic [5:0]            Funct,
  input  logic                  Zero,
  input  logic                  MemReady,
  output logic                  PCEn,
  output logic                  IorD,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegDst,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            PCSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  IllegalOp,
  output logic [COUNT_W-1:0]    InstrCount,
  output state_t                StateDbg
);

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q;
  logic                 go, retire;
  logic                 iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic                 srca, pcwrite, branch, branch_ne, illegal;
  logic [1:0]           srcb, pcsrc;
  aluop_t               alu_op;
  logic [2:0]           alu_ctrl;

  assign go = MEM_WAIT_EN ? MemReady : 1'b1;

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    iord      = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    srca      = 1'b0;
    srcb      = SRCB_B;
    pcsrc     = PCSRC_ALU;
    alu_op    = ALUOP_ADD;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        srcb    = SRCB_FOUR;
        irwrite = go;
        pcwrite = go;
        if (go) state_d = S_DECODE;
      end
      S_DECODE: begin
        srcb = SRCB_IMM_SH2;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE:       if (BNE_EN) state_d = S_BRANCH;
                        else        illegal = 1'b1;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      illegal = 1'b1;
        endcase
        // An illegal opcode still retires: the FSM returns to FETCH.
        if (illegal) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEMADR: begin
        srca    = 1'b1;
        srcb    = SRCB_IMM;
        state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        iord = 1'b1;
        if (go) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_MEMWRITE: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (go) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: begin
        srca    = 1'b1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        srca   = 1'b1;
        alu_op = ALUOP_SUB;
        pcsrc  = PCSRC_ALUOUT;
        if (BNE_EN && (Opcode == OP_BNE)) branch_ne = 1'b1;
        else                              branch    = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDIEX: begin
        srca    = 1'b1;
        srcb    = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + COUNT_W'(1);
    end
  end

  mips_alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct_i       (Funct),
    .alu_control_o (alu_ctrl)
  );

  // Ternaries (not AND-masking) so reset forces clean zeros even before the
  // first clock edge has initialised the state register.
  assign PCEn       = RST ? 1'b0 : (pcwrite | (branch & Zero) | (branch_ne & ~Zero));
  assign IorD       = RST ? 1'b0 : iord;
  assign MemWrite   = RST ? 1'b0 : memwrite;
  assign IRWrite    = RST ? 1'b0 : irwrite;
  assign RegDst     = RST ? 1'b0 : regdst;
  assign MemtoReg   = RST ? 1'b0 : memtoreg;
  assign RegWrite   = RST ? 1'b0 : regwrite;
  assign ALUSrcA    = RST ? 1'b0 : srca;
  assign ALUSrcB    = RST ? 2'b00 : srcb;
  assign PCSrc      = RST ? 2'b00 : pcsrc;
  assign ALUControl = RST ? '0 : ALU_CTRL_W'(alu_ctrl);
  assign IllegalOp  = RST ? 1'b0 : illegal;
  assign InstrCount = RST ? '0 : count_q;
  assign StateDbg   = RST ? S_FETCH : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control. Two instances share the stimulus:
// dut_a uses the default parameters, dut_b has MEM_WAIT_EN=0, BNE_EN=0 and
// a 2-bit InstrCount. Each cycle the expected control vector (with the
// expected count) is pushed when inputs are driven and popped for
// comparison just after, away from the rising edge.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Opcode = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;

  logic        a_pcen, a_iord, a_memw, a_irw, a_regdst, a_m2r, a_regw, a_srca, a_ill;
  logic [1:0]  a_srcb, a_pcsrc;
  logic [2:0]  a_aluc;
  logic [15:0] a_cnt;
  state_t      a_state;
  logic        b_pcen, b_iord, b_memw, b_irw, b_regdst, b_m2r, b_regw, b_srca, b_ill;
  logic [1:0]  b_srcb, b_pcsrc;
  logic [2:0]  b_aluc;
  logic [1:0]  b_cnt;
  state_t      b_state;

  always #5 CLK = ~CLK;

  mips_multicycle_control dut_a (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCEn(a_pcen), .IorD(a_iord), .MemWrite(a_memw),
    .IRWrite(a_irw), .RegDst(a_regdst), .MemtoReg(a_m2r), .RegWrite(a_regw),
    .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .PCSrc(a_pcsrc), .ALUControl(a_aluc),
    .IllegalOp(a_ill), .InstrCount(a_cnt), .StateDbg(a_state)
  );

  mips_multicycle_control #(
    .MEM_WAIT_EN(1'b0), .BNE_EN(1'b0), .COUNT_W(2)
  ) dut_b (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCEn(b_pcen), .IorD(b_iord), .MemWrite(b_memw),
    .IRWrite(b_irw), .RegDst(b_regdst), .MemtoReg(b_m2r), .RegWrite(b_regw),
    .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .PCSrc(b_pcsrc), .ALUControl(b_aluc),
    .IllegalOp(b_ill), .InstrCount(b_cnt), .StateDbg(b_state)
  );

  wire [31:0] obs_a = {a_cnt, a_pcen, a_iord, a_memw, a_irw, a_regdst, a_m2r,
                       a_regw, a_srca, a_srcb, a_pcsrc, a_aluc, a_ill};
  wire [31:0] obs_b = {14'b0, b_cnt, b_pcen, b_iord, b_memw, b_irw, b_regdst,
                       b_m2r, b_regw, b_srca, b_srcb, b_pcsrc, b_aluc, b_ill};

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic [1:0]  exp_cnt2 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // Control vector: PCEn IorD MemWrite IRWrite RegDst MemtoReg RegWrite
  // ALUSrcA ALUSrcB[1:0] PCSrc[1:0] ALUControl[2:0] IllegalOp
  function automatic logic [15:0] cv(input logic pcen, iord, memw, irw, regdst, m2r,
                                     regw, srca, input logic [1:0] srcb, pcsrc,
                                     input logic [2:0] aluc, input logic ill);
    return {pcen, iord, memw, irw, regdst, m2r, regw, srca, srcb, pcsrc, aluc, ill};
  endfunction

  function automatic logic [15:0] v_fetch(input logic g);
    return cv(g, 0, 0, g, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [15:0] v_decode(input logic ill);
    return cv(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, ill);
  endfunction
  function automatic logic [15:0] v_memadr();
    return cv(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [15:0] v_memread();
    return cv(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [15:0] v_memwb();
    return cv(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [15:0] v_memwrite();
    return cv(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [15:0] v_exec(input logic [2:0] aluc);
    return cv(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, aluc, 0);
  endfunction
  function automatic logic [15:0] v_aluwb();
    return cv(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [15:0] v_branch(input logic p);
    return cv(p, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
  endfunction
  function automatic logic [15:0] v_addiwb();
    return cv(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [15:0] v_jump();
    return cv(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0);
  endfunction

  // One clock cycle: drive at the falling edge, compare 1 time unit later.
  task automatic cyc(input string tag, input bit sel, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic rdy,
                     input logic [15:0] v);
    @(negedge CLK);
    RST = 1'b0; Opcode = op; Funct = fn; Zero = z; MemReady = rdy;
    exp_q.push_back(sel ? {14'b0, exp_cnt2, v} : {exp_cnt, v});
    #1;
    check(tag, sel ? obs_b : obs_a, exp_q.pop_front());
  endtask

  task automatic retired();
    exp_cnt++;
    exp_cnt2++;
  endtask

  // Leaves RST high; the next cyc() releases it so both instances start
  // their first checked cycle in FETCH together.
  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      RST = 1'b1; MemReady = 1'b0;
      #1;
      check("rst_out_a", obs_a, 32'h0);
      check("rst_out_b", obs_b, 32'h0);
    end
    exp_cnt = '0;
    exp_cnt2 = '0;
  endtask

  task automatic run_lw(input int rd_wait);
    cyc("lw_fetch", 0, OP_LW, 0, 0, 1, v_fetch(1));
    check("lw_st_fetch", 32'(a_state), 32'(S_FETCH));
    cyc("lw_decode", 0, OP_LW, 0, 0, 1, v_decode(0));
    check("lw_st_decode", 32'(a_state), 32'(S_DECODE));
    cyc("lw_memadr", 0, OP_LW, 0, 0, 1, v_memadr());
    check("lw_st_memadr", 32'(a_state), 32'(S_MEMADR));
    for (int i = 0; i < rd_wait; i++) cyc("lw_memread_hold", 0, OP_LW, 0, 0, 0, v_memread());
    cyc("lw_memread", 0, OP_LW, 0, 0, 1, v_memread());
    check("lw_st_memread", 32'(a_state), 32'(S_MEMREAD));
    cyc("lw_memwb", 0, OP_LW, 0, 0, 1, v_memwb());
    check("lw_st_memwb", 32'(a_state), 32'(S_MEMWB));
    retired();
  endtask

  task automatic run_r(input logic [5:0] fn, input logic [2:0] aluc);
    cyc("r_fetch", 0, OP_RTYPE, fn, 0, 1, v_fetch(1));
    cyc("r_decode", 0, OP_RTYPE, fn, 0, 1, v_decode(0));
    cyc("r_execute", 0, OP_RTYPE, fn, 0, 1, v_exec(aluc));
    cyc("r_aluwb", 0, OP_RTYPE, fn, 0, 1, v_aluwb());
    retired();
  endtask

  task automatic run_br(input logic [5:0] op, input logic z, input logic pcen);
    cyc("br_fetch", 0, op, 0, z, 1, v_fetch(1));
    cyc("br_decode", 0, op, 0, z, 1, v_decode(0));
    cyc("br_branch", 0, op, 0, z, 1, v_branch(pcen));
    retired();
  endtask

  task automatic run_sw(input int f_wait, input int w_wait);
    for (int i = 0; i < f_wait; i++) cyc("sw_fetch_hold", 0, OP_SW, 0, 0, 0, v_fetch(0));
    cyc("sw_fetch", 0, OP_SW, 0, 0, 1, v_fetch(1));
    cyc("sw_decode", 0, OP_SW, 0, 0, 1, v_decode(0));
    cyc("sw_memadr", 0, OP_SW, 0, 0, 1, v_memadr());
    for (int i = 0; i < w_wait; i++) cyc("sw_memwrite_hold", 0, OP_SW, 0, 0, 0, v_memwrite());
    cyc("sw_memwrite", 0, OP_SW, 0, 0, 1, v_memwrite());
    retired();
  endtask

  task automatic run_addi(input bit sel);
    cyc("addi_fetch", sel, OP_ADDI, 0, 0, 1, v_fetch(1));
    cyc("addi_decode", sel, OP_ADDI, 0, 0, 1, v_decode(0));
    cyc("addi_ex", sel, OP_ADDI, 0, 0, 1, v_memadr());
    cyc("addi_wb", sel, OP_ADDI, 0, 0, 1, v_addiwb());
    retired();
  endtask

  task automatic run_j(input bit sel);
    cyc("j_fetch", sel, OP_J, 0, 0, 1, v_fetch(1));
    cyc("j_decode", sel, OP_J, 0, 0, 1, v_decode(0));
    cyc("j_jump", sel, OP_J, 0, 0, 1, v_jump());
    retired();
  endtask

  task automatic run_illegal(input bit sel, input logic [5:0] op);
    cyc("ill_fetch", sel, op, 0, 0, 1, v_fetch(1));
    cyc("ill_decode", sel, op, 0, 0, 1, v_decode(1));
    retired();
  endtask

  logic [5:0] fn_tab[6]   = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
  logic [2:0] aluc_tab[6] = '{3'b110,    3'b010,    3'b000,    3'b001,    3'b111,    3'b000};

  initial begin
    do_reset();

    run_lw(0);
    for (int i = 0; i < 6; i++) run_r(fn_tab[i], aluc_tab[i]);
    run_br(OP_BEQ, 1'b1, 1'b1);
    run_br(OP_BEQ, 1'b0, 1'b0);
    run_br(OP_BNE, 1'b1, 1'b0);
    run_br(OP_BNE, 1'b0, 1'b1);
    run_sw(1, 3);
    run_lw(2);
    run_addi(0);
    run_j(0);
    run_illegal(0, 6'b111111);
    // Random funct values never seen in the table must still decode correctly.
    for (int i = 0; i < 4; i++) begin
      logic [5:0] fn;
      fn = 6'($urandom_range(0, 63));
      case (fn)
        6'b100000: run_r(fn, 3'b010);
        6'b100010: run_r(fn, 3'b110);
        6'b100100: run_r(fn, 3'b000);
        6'b100101: run_r(fn, 3'b001);
        6'b101010: run_r(fn, 3'b111);
        default:   run_r(fn, 3'b000);
      endcase
    end

    // Abort an lw while it waits in MEMREAD.
    cyc("abort_fetch", 0, OP_LW, 0, 0, 1, v_fetch(1));
    cyc("abort_decode", 0, OP_LW, 0, 0, 1, v_decode(0));
    cyc("abort_memadr", 0, OP_LW, 0, 0, 1, v_memadr());
    cyc("abort_memread", 0, OP_LW, 0, 0, 0, v_memread());
    do_reset();
    cyc("abort_refetch", 0, OP_J, 0, 0, 0, v_fetch(0));
    check("abort_state", 32'(a_state), 32'(S_FETCH));
    run_j(0);

    // Second instance: bne is illegal, MemReady ignored, 2-bit counter wraps.
    do_reset();
    run_illegal(1, OP_BNE);
    run_illegal(1, 6'b111111);
    run_j(1);
    run_addi(1);
    cyc("wrap_fetch", 1, OP_SW, 0, 0, 0, v_fetch(1));
    cyc("nowait_decode", 1, OP_SW, 0, 0, 0, v_decode(0));
    cyc("nowait_memadr", 1, OP_SW, 0, 0, 0, v_memadr());
    cyc("nowait_memwrite", 1, OP_SW, 0, 0, 0, v_memwrite());
    retired();
    cyc("nowait_refetch", 1, OP_J, 0, 0, 0, v_fetch(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
